// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one adder among N_REQ requesters and
// returns results through a one-entry response register. Optional: ADDER_ARB_CARRY_EN.
module adder_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_sum,
    output logic [ID_W-1:0]        resp_id
`ifdef ADDER_ARB_CARRY_EN
    ,
    output logic                   resp_carry
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   scan_idx;
    int                scan_int;
    logic              found;
    logic              can_accept;
    logic              grant;
    logic [WIDTH-1:0]  a_arr [N_REQ];
    logic [WIDTH-1:0]  b_arr [N_REQ];
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        scan_int = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_int = int'(rr_ptr) + k;
            if (scan_int >= N_REQ) begin
                scan_int = scan_int - N_REQ;
            end
            scan_idx = ID_W'(scan_int);
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign can_accept = (state == EMPTY) || (resp_valid && resp_ready);

    // Reset gates the grant: state already reads EMPTY while reset is high.
    always_comb begin
        req_ready = '0;
        if (!reset && can_accept && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign grant = |req_ready;
    assign a_sel = a_arr[winner];
    assign b_sel = b_arr[winner];

`ifdef ADDER_ARB_CARRY_EN
    logic [WIDTH:0] sum_full;
    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};
`else
    logic [WIDTH-1:0] sum_full;
    assign sum_full = a_sel + b_sel;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (grant) state_next = FULL;
            FULL:  if (!grant && resp_ready) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        resp_valid = (state == FULL);
    end

    // NOTE: the response datapath registers are reset too, because their cleared values are observable outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_sum <= '0;
            resp_id  <= '0;
            rr_ptr   <= '0;
`ifdef ADDER_ARB_CARRY_EN
            resp_carry <= 1'b0;
`endif
        end else if (grant) begin
            resp_sum <= sum_full[WIDTH-1:0];
            resp_id  <= winner;
            rr_ptr   <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
`ifdef ADDER_ARB_CARRY_EN
            resp_carry <= sum_full[WIDTH];
`endif
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed scenarios plus a
// randomized run against a cycle-level transaction model.
module tb_adder_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [W-1:0]   resp_sum;
    logic [1:0]     resp_id;
`ifdef ADDER_ARB_CARRY_EN
    logic           resp_carry;
`endif

    logic [W-1:0] a_op [N];
    logic [W-1:0] b_op [N];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a_op[i];
            req_b[i*W +: W] = b_op[i];
        end
    end

    adder_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id)
`ifdef ADDER_ARB_CARRY_EN
        ,
        .resp_carry (resp_carry)
`endif
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_sum !== 8'd0 || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b sum=%h id=%0d want 0/00/0", resp_valid, resp_sum, resp_id);
        end
        do_reset();
    endtask

    task automatic test_single;
        do_reset();
        a_op[2] = 8'd3;
        b_op[2] = 8'd5;
        req_valid  = 4'b0100;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_sum !== 8'd8 || resp_id !== 2'd2) begin
            errors++;
            $display("FAIL single_resp: got v=%b sum=%0d id=%0d want 1/8/2", resp_valid, resp_sum, resp_id);
        end
        tick();
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got v=%b want 0", resp_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp_ready;
        int           prev;
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_op[i] = 8'(i * 10 + 1);
            b_op[i] = 8'(i);
        end
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_ready = 4'(1 << (k % N));
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_ready);
            end
            if (k > 0) begin
                prev = (k - 1) % N;
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'(prev) || resp_sum !== 8'(prev * 11 + 1)) begin
                    errors++;
                    $display("FAIL rr_resp[%0d]: got v=%b id=%0d sum=%0d want 1/%0d/%0d",
                             k, resp_valid, resp_id, resp_sum, prev, prev * 11 + 1);
                end
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        a_op[0] = 8'd10; b_op[0] = 8'd20;
        a_op[1] = 8'd7;  b_op[1] = 8'd9;
        req_valid  = 4'b0011;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_first: got %b want 0001", req_ready);
        end
        tick();
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_sum !== 8'd30 || resp_id !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b sum=%0d id=%0d want 0000/1/30/0",
                         k, req_ready, resp_valid, resp_sum, resp_id);
            end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010 || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b id=%0d want 0010/0", req_ready, resp_id);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 8'd16) begin
            errors++;
            $display("FAIL bp_next: got v=%b id=%0d sum=%0d want 1/1/16", resp_valid, resp_id, resp_sum);
        end
        tick();
    endtask

    task automatic test_wrap;
        do_reset();
        a_op[0] = 8'hF0; b_op[0] = 8'h20;
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        tick();
        a_op[1] = 8'h01; b_op[1] = 8'h02;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (resp_sum !== 8'h10) begin
            errors++;
            $display("FAIL wrap_sum: got %h want 10", resp_sum);
        end
`ifdef ADDER_ARB_CARRY_EN
        checks++;
        if (resp_carry !== 1'b1) begin
            errors++;
            $display("FAIL wrap_carry: got %b want 1", resp_carry);
        end
`endif
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (resp_sum !== 8'h03 || resp_id !== 2'd1) begin
            errors++;
            $display("FAIL small_sum: got %h id=%0d want 03/1", resp_sum, resp_id);
        end
`ifdef ADDER_ARB_CARRY_EN
        checks++;
        if (resp_carry !== 1'b0) begin
            errors++;
            $display("FAIL small_carry: got %b want 0", resp_carry);
        end
`endif
        tick();
    endtask

    task automatic test_pointer_skip;
        do_reset();
        a_op[0] = 8'd1; b_op[0] = 8'd1;
        a_op[3] = 8'd4; b_op[3] = 8'd4;
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        tick();
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL skip_grant3: got %b want 1000", req_ready);
        end
        tick();
        #1;
        checks++;
        if (req_ready !== 4'b0001 || resp_id !== 2'd3 || resp_sum !== 8'd8) begin
            errors++;
            $display("FAIL skip_grant0: got rdy=%b id=%0d sum=%0d want 0001/3/8", req_ready, resp_id, resp_sum);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (resp_id !== 2'd0 || resp_sum !== 8'd2) begin
            errors++;
            $display("FAIL skip_resp0: got id=%0d sum=%0d want 0/2", resp_id, resp_sum);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        a_op[2] = 8'd50; b_op[2] = 8'd60;
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        tick();
        req_valid = 4'b1010;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin
            errors++;
            $display("FAIL mid_full: got v=%b id=%0d want 1/2", resp_valid, resp_id);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_sum !== 8'd0 || resp_id !== 2'd0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: got v=%b sum=%0d id=%0d rdy=%b want 0/0/0/0000",
                     resp_valid, resp_sum, resp_id, req_ready);
        end
        tick();
        reset = 1'b0;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_first_grant: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    // Transaction model: pointer, pending-response slot and per-requester grant counts.
    task automatic test_random;
        int           m_ptr;
        bit           m_full;
        int           m_sum;
        int           m_id;
        int           m_carry;
        int           w;
        bit           can;
        logic [N-1:0] exp_ready;
        int           total;
        do_reset();
        m_ptr = 0;
        m_full = 0;
        m_sum = 0;
        m_id = 0;
        m_carry = 0;
        w = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (w == i) begin
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && ($urandom_range(0, 3) != 0)) begin
                    req_valid[i] = 1'b1;
                    a_op[i] = 8'($urandom_range(0, 255));
                    b_op[i] = 8'($urandom_range(0, 255));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (resp_valid !== m_full || (m_full && (resp_sum !== 8'(m_sum) || resp_id !== 2'(m_id)))) begin
                errors++;
                $display("FAIL rand_resp[%0d]: got v=%b sum=%0d id=%0d want %0d/%0d/%0d",
                         cyc, resp_valid, resp_sum, resp_id, m_full, m_sum, m_id);
            end
`ifdef ADDER_ARB_CARRY_EN
            if (m_full) begin
                checks++;
                if (resp_carry !== 1'(m_carry)) begin
                    errors++;
                    $display("FAIL rand_carry[%0d]: got %b want %0d", cyc, resp_carry, m_carry);
                end
            end
`endif
            can = !m_full || resp_ready;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % N]) begin
                    w = (m_ptr + k) % N;
                end
            end
            if (!can) begin
                w = -1;
            end
            exp_ready = (w >= 0) ? 4'(1 << w) : 4'b0000;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got %b want %b", cyc, req_ready, exp_ready);
            end
            if (w >= 0) begin
                total   = int'(a_op[w]) + int'(b_op[w]);
                m_full  = 1;
                m_sum   = total % 256;
                m_carry = total / 256;
                m_id    = w;
                m_ptr   = (w + 1) % N;
            end else if (m_full && resp_ready) begin
                m_full = 0;
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_pointer_skip();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that time-shares one combinational 8-bit adder datapath among several requesters in the pixel-scaling accelerator. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes the sum through a single adder instance, and returns the result with the requester index through a one-entry registered response buffer. The buffer has its own valid/ready handshake.

## Interface
Parameters:
- N_REQ, 4: number of requesters; 2..8.
- WIDTH, 8: operand and sum width.
- ID_W, 2: requester index width; must equal ceil(log2(N_REQ)).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  bit i: requester i presents operands.
- req_ready  out  N_REQ  bit i: requester i granted this cycle; at most one bit set.
- req_a  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B; same packing as req_a.
- resp_valid  out  1  response register holds a result.
- resp_ready  in  1  consumer accepts the response.
- resp_sum  out  WIDTH  registered (a+b) mod 2^WIDTH.
- resp_id  out  ID_W  index of the requester that produced resp_sum.
- resp_carry  out  1  registered carry-out; present only with ADDER_ARB_CARRY_EN.

## Operation
- State machine:
  - EMPTY: response register free.
  - FULL: response register holds an undelivered result.
- can_accept = (state==EMPTY) | (resp_valid & resp_ready).
- Arbitration:
  - Round-robin pointer rr_ptr (ID_W bits) names the highest-priority index.
  - Search order: rr_ptr, rr_ptr+1, ... mod N_REQ.
  - The first index with req_valid set is the winner.
- Grant:
  - req_ready[winner] = can_accept & any(req_valid); all other bits are 0.
  - req_ready may depend combinationally on req_valid and resp_ready. Requesters must not derive req_valid from req_ready.
- On a transfer (req_valid[i] & req_ready[i]):
  - Winner's operands drive the shared adder.
  - resp_sum <= sum, resp_id <= i, state <= FULL.
  - rr_ptr <= (i+1) mod N_REQ.
- On a drain without a new grant (resp_valid & resp_ready, no grant): state <= EMPTY.
- Drain and grant in the same cycle: register reloads with the new result and stays FULL. Result: one result per cycle sustained throughput.
- FULL & !resp_ready:
  - resp_sum, resp_id and resp_carry hold stable.
  - req_ready = 0.
  - rr_ptr holds.
- Idle cycles (no req_valid): rr_ptr holds.
- Arithmetic: unsigned WIDTH-bit add. Overflow wraps, e.g. 8'hF0 + 8'h20 = 8'h10. Carry is discarded unless ADDER_ARB_CARRY_EN is defined.
- Requester behaviour: a requester may hold req_valid across cycles. Its operands must stay stable until granted. The arbiter never grants a requester whose req_valid is low.

## Timing
- Reset values (asynchronous, immediate):
  - state = EMPTY, resp_valid = 0.
  - resp_sum = 0, resp_id = 0, resp_carry = 0.
  - rr_ptr = 0.
  - req_ready = 0 while reset is asserted.
- Latency: transfer in cycle t gives resp_valid = 1 with the result in cycle t+1.
- Throughput: 1 transfer per cycle while resp_ready = 1.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once in every N_REQ consecutive grants.
- Reset mid-operation:
  - Pending response is discarded.
  - Pointer returns to 0.
  - First grant after deassertion goes to the lowest valid index.

## Configuration
- ADDER_ARB_CARRY_EN defined:
  - Adder is computed at WIDTH+1 bits.
  - resp_carry port exists and registers bit WIDTH alongside resp_sum, with the same hold and reset rules.
- Not defined:
  - resp_carry port is absent.
  - Adder is WIDTH bits only.

## Test plan
- Single requester: reset, then req_valid=4'b0100, a=8'd3, b=8'd5 -> req_ready=4'b0100 same cycle; next cycle resp_valid=1, resp_sum=8'd8, resp_id=2.
- Round-robin: req_valid=4'b1111 held, resp_ready=1 -> grant order 0,1,2,3,0,1,2,3; one resp per cycle with matching resp_id.
- Backpressure: after one response, resp_ready=0 for 3 cycles with req_valid=4'b0011 -> req_ready=0; resp_sum/resp_id stable; the pending response is delivered when resp_ready rises, and the next grant goes in that same cycle.
- Wrap/carry: a=8'hF0, b=8'h20 -> resp_sum=8'h10; with ADDER_ARB_CARRY_EN, resp_carry=1; 8'h01+8'h02 gives resp_carry=0.
- Pointer skip: rr_ptr=1, req_valid=4'b1001 -> grant 3, then rr_ptr=0 and the next grant is 0.
- Reset mid-operation: assert reset while FULL with resp_ready=0 -> resp_valid=0 and all outputs 0 immediately; after release with req_valid=4'b1010 -> first grant goes to requester 1.
